// File: rtl/lii_mux_stream_wrapper_pkg.sv
// Shared LII definitions: tag width, drop-counter ceiling, log2 helper.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package lii_pkg;

  localparam int TAG_W = 8;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  // Address width for a table of n entries; never less than 1 bit so that
  // single-entry tables still get a legal pointer.
  function automatic int lii_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/lii_mux_stream_wrapper_if.sv
// Bundles the phy channel pair and the kernel-side stream buses.
// Latency: n/a (wiring only).
// Backpressure: carried by the tready lines in both directions.
interface lii_mux_stream_wrapper_if #(
  parameter int NIN  = 2,
  parameter int NOUT = 2,
  parameter int PW   = 128,
  parameter int DW   = 96
);
  import lii_pkg::*;

  logic [PW-1:0]       lii_in_p0_tdata;
  logic                lii_in_p0_tvalid;
  logic                lii_in_p0_tready;
  logic [TAG_W-1:0]    lii_in_p0_src;
  logic [TAG_W-1:0]    lii_in_p0_dst;

  logic [PW-1:0]       lii_out_p0_tdata;
  logic                lii_out_p0_tvalid;
  logic                lii_out_p0_tready;
  logic [TAG_W-1:0]    lii_out_p0_src;
  logic [TAG_W-1:0]    lii_out_p0_dst;

  logic [NIN*DW-1:0]   k_in_tdata;
  logic [NIN-1:0]      k_in_tvalid;
  logic [NIN-1:0]      k_in_tready;

  logic [NOUT*DW-1:0]  k_out_tdata;
  logic [NOUT-1:0]     k_out_tvalid;
  logic [NOUT-1:0]     k_out_tready;

  logic                ce;
  logic [15:0]         drop_cnt;

  // Wrapper side of the bundle.
  modport slave (
    input  lii_in_p0_tdata, lii_in_p0_tvalid, lii_in_p0_src, lii_in_p0_dst,
    output lii_in_p0_tready,
    output lii_out_p0_tdata, lii_out_p0_tvalid, lii_out_p0_src, lii_out_p0_dst,
    input  lii_out_p0_tready,
    output k_in_tdata, k_in_tvalid,
    input  k_in_tready,
    input  k_out_tdata, k_out_tvalid,
    output k_out_tready,
    output ce, drop_cnt
  );

  // Environment side (phy plus kernel) of the bundle.
  modport master (
    output lii_in_p0_tdata, lii_in_p0_tvalid, lii_in_p0_src, lii_in_p0_dst,
    input  lii_in_p0_tready,
    input  lii_out_p0_tdata, lii_out_p0_tvalid, lii_out_p0_src, lii_out_p0_dst,
    output lii_out_p0_tready,
    input  k_in_tdata, k_in_tvalid,
    output k_in_tready,
    output k_out_tdata, k_out_tvalid,
    input  k_out_tready,
    input  ce, drop_cnt
  );

endinterface

// File: rtl/lii_sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-bit pointers.
// Latency: a push is visible at the head one cycle after acceptance.
// Backpressure: push_rdy drops when full; a pop on the same cycle does not free the slot.
module lii_sync_fifo
  import lii_pkg::*;
#(
  parameter int DW    = 96,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  output logic          push_rdy,
  output logic          pop_vld,
  output logic [DW-1:0] pop_dat,
  input  logic          pop_rdy
);

  localparam int AW = lii_clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_rdy = ~full;
  assign pop_vld  = ~empty;
  assign pop_dat  = mem[rd_ptr[AW-1:0]];
  assign do_push  = push_vld & ~full;
  assign do_pop   = pop_rdy & ~empty;

  // Pointer update; reset empties the FIFO and discards anything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/lii_mux_stream_wrapper.sv
// Demuxes phy beats into per-stream FIFOs by dst tag; RR-muxes kernel outputs onto the phy.
// Latency: 1 cycle phy-in to kernel-in, 1 cycle kernel-out to phy-out.
// Backpressure: per-stream full stalls phy input; phy-out stall freezes output stage and drops ce.
module lii_mux_stream_wrapper
  import lii_pkg::*;
#(
  parameter int NIN      = 2,
  parameter int NOUT     = 2,
  parameter int PW       = 128,
  parameter int DW       = 96,
  parameter int DEPTH    = 4,
  parameter int IN_BASE  = 0,
  parameter int SRC_ID   = 0,
  parameter int DST_BASE = 0
) (
  input  logic                    aclk,
  input  logic                    arst,
  lii_mux_stream_wrapper_if.slave bus
);

  localparam int PTRW = lii_clog2(NOUT);

  // ---------------- input demux ----------------
  logic [TAG_W-1:0] idx;
  logic             in_range;
  logic             sel_rdy;
  logic [NIN-1:0]   push_vld;
  logic [NIN-1:0]   push_rdy;
  logic [NIN-1:0]   fifo_vld;
  logic [NIN*DW-1:0] fifo_dat;
  logic [DW-1:0]    in_dat;
  logic [15:0]      drop_cnt;
  logic             unused_in;

  // Tag arithmetic wraps at 8 bits, so tags below IN_BASE land out of range.
  assign idx      = bus.lii_in_p0_dst - TAG_W'(IN_BASE);
  assign in_range = (int'(idx) < NIN);
  assign in_dat   = bus.lii_in_p0_tdata[DW-1:0];
  assign unused_in = ^{bus.lii_in_p0_src, bus.lii_in_p0_tdata};

  // Steer valid to the addressed FIFO; out-of-range tags are always accepted.
  always_comb begin
    sel_rdy  = 1'b1;
    push_vld = '0;
    for (int i = 0; i < NIN; i++) begin
      if (idx == TAG_W'(i)) begin
        sel_rdy     = push_rdy[i];
        push_vld[i] = bus.lii_in_p0_tvalid;
      end
    end
  end

  assign bus.lii_in_p0_tready = sel_rdy;

  for (genvar g = 0; g < NIN; g++) begin : g_fifo
    lii_sync_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk      (aclk),
      .rst      (arst),
      .push_vld (push_vld[g]),
      .push_dat (in_dat),
      .push_rdy (push_rdy[g]),
      .pop_vld  (fifo_vld[g]),
      .pop_dat  (fifo_dat[g*DW +: DW]),
      .pop_rdy  (bus.k_in_tready[g])
    );
  end

  assign bus.k_in_tvalid = fifo_vld;
  assign bus.k_in_tdata  = fifo_dat;

  // Count discarded beats, holding at the ceiling rather than wrapping.
  always_ff @(posedge aclk) begin
    if (arst) begin
      drop_cnt <= '0;
    end else if (bus.lii_in_p0_tvalid && !in_range && drop_cnt != DROP_MAX) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt;

  // ---------------- output arbiter + register ----------------
  logic             out_vld;
  logic [PW-1:0]    out_dat;
  logic [TAG_W-1:0] out_dst;
  logic [PTRW-1:0]  rr_ptr;
  logic             load;
  logic             found;
  logic [PTRW-1:0]  grant;
  logic [PTRW-1:0]  nxt_ptr;
  logic [DW-1:0]    gnt_dat;
  logic [NOUT-1:0]  gnt_rdy;

  assign load = ~out_vld | bus.lii_out_p0_tready;

  // Cyclic search from rr_ptr: first the streams at/above the pointer, then wrap to 0.
  always_comb begin
    found   = 1'b0;
    grant   = '0;
    gnt_dat = '0;
    for (int s = 0; s < NOUT; s++) begin
      if (!found && bus.k_out_tvalid[s] && int'(rr_ptr) <= s) begin
        found   = 1'b1;
        grant   = PTRW'(s);
        gnt_dat = bus.k_out_tdata[s*DW +: DW];
      end
    end
    for (int s = 0; s < NOUT; s++) begin
      if (!found && bus.k_out_tvalid[s]) begin
        found   = 1'b1;
        grant   = PTRW'(s);
        gnt_dat = bus.k_out_tdata[s*DW +: DW];
      end
    end
  end

  assign nxt_ptr = (int'(grant) == NOUT - 1) ? '0 : grant + PTRW'(1);

  // Only the granted stream sees ready, and only when the register can take a beat.
  always_comb begin
    gnt_rdy = '0;
    for (int s = 0; s < NOUT; s++) begin
      gnt_rdy[s] = load && found && (grant == PTRW'(s));
    end
  end

  assign bus.k_out_tready = gnt_rdy;

  // Output register: loads on grant, empties when nothing is offered, holds under stall.
  always_ff @(posedge aclk) begin
    if (arst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_dst <= TAG_W'(DST_BASE);
      rr_ptr  <= '0;
    end else if (load) begin
      if (found) begin
        out_vld <= 1'b1;
        out_dat <= PW'(gnt_dat);
        out_dst <= TAG_W'(DST_BASE) + TAG_W'(grant);
        rr_ptr  <= nxt_ptr;
      end else begin
        out_vld <= 1'b0;
      end
    end
  end

  assign bus.lii_out_p0_tvalid = out_vld;
  assign bus.lii_out_p0_tdata  = out_dat;
  assign bus.lii_out_p0_dst    = out_dst;
  assign bus.lii_out_p0_src    = TAG_W'(SRC_ID);
  assign bus.ce                = ~(out_vld & ~bus.lii_out_p0_tready);

endmodule

// File: tb/tb_lii_mux_stream_wrapper.sv
// Self-checking bench: directed scenarios plus a randomized run against a queue model.
// Latency: n/a.
// Backpressure: exercised on both the phy input and phy output sides.
module tb_lii_mux_stream_wrapper;

  localparam int NIN      = 2;
  localparam int NOUT     = 2;
  localparam int PW       = 128;
  localparam int DW       = 96;
  localparam int DEPTH    = 4;
  localparam int IN_BASE  = 0;
  localparam int SRC_ID   = 33;
  localparam int DST_BASE = 4;

  logic aclk;
  logic arst;
  int   total;
  int   bad;

  lii_mux_stream_wrapper_if #(.NIN(NIN), .NOUT(NOUT), .PW(PW), .DW(DW)) bus ();

  lii_mux_stream_wrapper #(
    .NIN(NIN), .NOUT(NOUT), .PW(PW), .DW(DW), .DEPTH(DEPTH),
    .IN_BASE(IN_BASE), .SRC_ID(SRC_ID), .DST_BASE(DST_BASE)
  ) dut (
    .aclk (aclk),
    .arst (arst),
    .bus  (bus.slave)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Model queues for the randomized run.
  logic [DW-1:0] mq [NIN][$];

  function automatic logic [DW-1:0] beat(input int c, input int s);
    beat = {16'(s + 1), 48'h0000_C0DE_0000, 32'(c)};
  endfunction

  function automatic logic [DW-1:0] rnd_dw();
    rnd_dw = {$urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    bus.lii_in_p0_tdata   = '0;
    bus.lii_in_p0_tvalid  = 1'b0;
    bus.lii_in_p0_src     = '0;
    bus.lii_in_p0_dst     = 8'(IN_BASE);
    bus.lii_out_p0_tready = 1'b1;
    bus.k_in_tready       = '0;
    bus.k_out_tdata       = '0;
    bus.k_out_tvalid      = '0;
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    arst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    arst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    bus.lii_in_p0_tvalid  = 1'b1;
    bus.lii_in_p0_dst     = 8'(IN_BASE);
    bus.lii_in_p0_tdata   = {32'hFFFF_FFFF, beat(1, 0)};
    bus.k_out_tvalid      = 2'b11;
    bus.k_out_tdata       = {beat(2, 1), beat(2, 0)};
    bus.lii_out_p0_tready = 1'b0;
    repeat (3) @(negedge aclk);
    arst = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    arst = 1'b0;
    idle_inputs();
    bus.lii_out_p0_tready = 1'b0;
    #1;
    total++; if (bus.k_in_tvalid !== '0) begin bad++; $display("FAIL rst_k_in_tvalid got=%b exp=0", bus.k_in_tvalid); end
    total++; if (bus.lii_out_p0_tvalid !== 1'b0) begin bad++; $display("FAIL rst_out_tvalid got=%b exp=0", bus.lii_out_p0_tvalid); end
    total++; if (bus.lii_out_p0_tdata !== '0) begin bad++; $display("FAIL rst_out_tdata got=%h exp=0", bus.lii_out_p0_tdata); end
    total++; if (bus.lii_out_p0_dst !== 8'(DST_BASE)) begin bad++; $display("FAIL rst_out_dst got=%0d exp=%0d", bus.lii_out_p0_dst, DST_BASE); end
    total++; if (bus.drop_cnt !== 16'd0) begin bad++; $display("FAIL rst_drop_cnt got=%0d exp=0", bus.drop_cnt); end
    total++; if (bus.ce !== 1'b1) begin bad++; $display("FAIL rst_ce got=%b exp=1", bus.ce); end
    total++; if (bus.lii_in_p0_tready !== 1'b1) begin bad++; $display("FAIL rst_in_tready got=%b exp=1", bus.lii_in_p0_tready); end
    bus.lii_out_p0_tready = 1'b1;
  endtask

  task automatic test_demux();
    @(negedge aclk);
    bus.k_in_tready      = '0;
    bus.lii_in_p0_tvalid = 1'b1;
    bus.lii_in_p0_dst    = 8'(IN_BASE + 1);
    bus.lii_in_p0_tdata  = {32'hDEAD_BEEF, 96'hA5};
    #1;
    total++; if (bus.lii_in_p0_tready !== 1'b1) begin bad++; $display("FAIL demux_rdy1 got=%b exp=1", bus.lii_in_p0_tready); end
    @(negedge aclk);
    bus.lii_in_p0_dst    = 8'(IN_BASE);
    bus.lii_in_p0_tdata  = {32'hCAFE_F00D, 96'h3C};
    #1;
    total++; if (bus.k_in_tvalid !== 2'b10) begin bad++; $display("FAIL demux_lat got=%b exp=10", bus.k_in_tvalid); end
    @(negedge aclk);
    bus.lii_in_p0_tvalid = 1'b0;
    #1;
    total++; if (bus.k_in_tvalid !== 2'b11) begin bad++; $display("FAIL demux_vld got=%b exp=11", bus.k_in_tvalid); end
    total++; if (bus.k_in_tdata[0 +: DW] !== 96'h3C) begin bad++; $display("FAIL demux_head0 got=%h exp=3c", bus.k_in_tdata[0 +: DW]); end
    total++; if (bus.k_in_tdata[DW +: DW] !== 96'hA5) begin bad++; $display("FAIL demux_head1 got=%h exp=a5", bus.k_in_tdata[DW +: DW]); end
    bus.k_in_tready = 2'b11;
    @(negedge aclk);
    bus.k_in_tready = '0;
    #1;
    total++; if (bus.k_in_tvalid !== 2'b00) begin bad++; $display("FAIL demux_drain got=%b exp=00", bus.k_in_tvalid); end
  endtask

  task automatic test_full_fifo();
    for (int n = 0; n < 4; n++) begin
      @(negedge aclk);
      bus.k_in_tready      = '0;
      bus.lii_in_p0_tvalid = 1'b1;
      bus.lii_in_p0_dst    = 8'(IN_BASE);
      bus.lii_in_p0_tdata  = PW'(96'h100 + 96'(n));
      #1;
      total++; if (bus.lii_in_p0_tready !== 1'b1) begin bad++; $display("FAIL full_acc%0d got=%b exp=1", n, bus.lii_in_p0_tready); end
    end
    @(negedge aclk);
    bus.lii_in_p0_tdata = PW'(96'h104);
    #1;
    total++; if (bus.lii_in_p0_tready !== 1'b0) begin bad++; $display("FAIL full_block got=%b exp=0", bus.lii_in_p0_tready); end
    total++; if (bus.k_in_tdata[0 +: DW] !== 96'h100) begin bad++; $display("FAIL full_head got=%h exp=100", bus.k_in_tdata[0 +: DW]); end
    bus.k_in_tready = 2'b01;
    #1;
    total++; if (bus.lii_in_p0_tready !== 1'b0) begin bad++; $display("FAIL full_popsame got=%b exp=0", bus.lii_in_p0_tready); end
    @(negedge aclk);
    bus.k_in_tready = '0;
    #1;
    total++; if (bus.lii_in_p0_tready !== 1'b1) begin bad++; $display("FAIL full_after_pop got=%b exp=1", bus.lii_in_p0_tready); end
    @(negedge aclk);
    bus.lii_in_p0_tvalid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      bus.k_in_tready = 2'b01;
      #1;
      total++; if (bus.k_in_tdata[0 +: DW] !== 96'h100 + 96'(n)) begin bad++; $display("FAIL full_order%0d got=%h exp=%h", n, bus.k_in_tdata[0 +: DW], 96'h100 + 96'(n)); end
      @(negedge aclk);
    end
    bus.k_in_tready = '0;
    #1;
    total++; if (bus.k_in_tvalid[0] !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", bus.k_in_tvalid[0]); end
  endtask

  task automatic test_bad_dst();
    for (int n = 0; n < 3; n++) begin
      @(negedge aclk);
      bus.lii_in_p0_tvalid = 1'b1;
      bus.lii_in_p0_dst    = 8'd7;
      bus.lii_in_p0_tdata  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      total++; if (bus.lii_in_p0_tready !== 1'b1) begin bad++; $display("FAIL bad_rdy%0d got=%b exp=1", n, bus.lii_in_p0_tready); end
    end
    @(negedge aclk);
    bus.lii_in_p0_tvalid = 1'b0;
    #1;
    total++; if (bus.drop_cnt !== 16'd3) begin bad++; $display("FAIL bad_drop got=%0d exp=3", bus.drop_cnt); end
    total++; if (bus.k_in_tvalid !== 2'b00) begin bad++; $display("FAIL bad_fifo got=%b exp=00", bus.k_in_tvalid); end
  endtask

  task automatic test_rr();
    for (int c = 0; c < 8; c++) begin
      @(negedge aclk);
      bus.lii_out_p0_tready = 1'b1;
      bus.k_out_tvalid      = 2'b11;
      bus.k_out_tdata       = {beat(c, 1), beat(c, 0)};
      #1;
      total++; if (bus.k_out_tready !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_rdy c=%0d got=%b", c, bus.k_out_tready); end
      if (c > 0) begin
        total++; if (bus.lii_out_p0_tvalid !== 1'b1) begin bad++; $display("FAIL rr_vld c=%0d got=%b exp=1", c, bus.lii_out_p0_tvalid); end
        total++; if (bus.lii_out_p0_dst !== 8'(DST_BASE + (c - 1) % 2)) begin bad++; $display("FAIL rr_dst c=%0d got=%0d exp=%0d", c, bus.lii_out_p0_dst, DST_BASE + (c - 1) % 2); end
        total++; if (bus.lii_out_p0_tdata !== PW'(beat(c - 1, (c - 1) % 2))) begin bad++; $display("FAIL rr_dat c=%0d got=%h", c, bus.lii_out_p0_tdata); end
        total++; if (bus.lii_out_p0_src !== 8'(SRC_ID)) begin bad++; $display("FAIL rr_src got=%0d exp=%0d", bus.lii_out_p0_src, SRC_ID); end
      end
    end
    @(negedge aclk);
    bus.k_out_tvalid = '0;
    #1;
    total++; if (bus.lii_out_p0_dst !== 8'(DST_BASE + 1)) begin bad++; $display("FAIL rr_last_dst got=%0d exp=%0d", bus.lii_out_p0_dst, DST_BASE + 1); end
    total++; if (bus.lii_out_p0_tdata !== PW'(beat(7, 1))) begin bad++; $display("FAIL rr_last_dat got=%h", bus.lii_out_p0_tdata); end
    total++; if (bus.k_out_tready !== 2'b00) begin bad++; $display("FAIL rr_idle_rdy got=%b exp=00", bus.k_out_tready); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d0, d1, d2;
    d0 = rnd_dw(); d1 = rnd_dw(); d2 = rnd_dw();
    @(negedge aclk);
    bus.lii_out_p0_tready = 1'b0;
    bus.k_out_tvalid      = 2'b01;
    bus.k_out_tdata       = {rnd_dw(), d0};
    #1;
    total++; if (bus.k_out_tready !== 2'b01) begin bad++; $display("FAIL bp_load_rdy got=%b exp=01", bus.k_out_tready); end
    total++; if (bus.ce !== 1'b1) begin bad++; $display("FAIL bp_ce_idle got=%b exp=1", bus.ce); end
    for (int n = 0; n < 2; n++) begin
      @(negedge aclk);
      bus.k_out_tvalid = 2'b11;
      bus.k_out_tdata  = {d2, d1};
      #1;
      total++; if (bus.ce !== 1'b0) begin bad++; $display("FAIL bp_ce%0d got=%b exp=0", n, bus.ce); end
      total++; if (bus.k_out_tready !== 2'b00) begin bad++; $display("FAIL bp_krdy%0d got=%b exp=00", n, bus.k_out_tready); end
      total++; if (bus.lii_out_p0_tdata !== PW'(d0)) begin bad++; $display("FAIL bp_hold_dat%0d got=%h exp=%h", n, bus.lii_out_p0_tdata, d0); end
      total++; if (bus.lii_out_p0_dst !== 8'(DST_BASE)) begin bad++; $display("FAIL bp_hold_dst%0d got=%0d exp=%0d", n, bus.lii_out_p0_dst, DST_BASE); end
      total++; if (bus.lii_out_p0_tvalid !== 1'b1) begin bad++; $display("FAIL bp_hold_vld%0d got=%b exp=1", n, bus.lii_out_p0_tvalid); end
    end
    @(negedge aclk);
    bus.lii_out_p0_tready = 1'b1;
    #1;
    total++; if (bus.ce !== 1'b1) begin bad++; $display("FAIL bp_release_ce got=%b exp=1", bus.ce); end
    total++; if (bus.k_out_tready !== 2'b10) begin bad++; $display("FAIL bp_release_rdy got=%b exp=10", bus.k_out_tready); end
    @(negedge aclk);
    bus.k_out_tvalid = '0;
    #1;
    total++; if (bus.lii_out_p0_tdata !== PW'(d2)) begin bad++; $display("FAIL bp_next_dat got=%h exp=%h", bus.lii_out_p0_tdata, d2); end
    total++; if (bus.lii_out_p0_dst !== 8'(DST_BASE + 1)) begin bad++; $display("FAIL bp_next_dst got=%0d exp=%0d", bus.lii_out_p0_dst, DST_BASE + 1); end
  endtask

  task automatic test_random();
    logic          m_ov;
    logic [PW-1:0] m_od;
    int            m_dst;
    int            m_ptr;
    int            m_drop;
    int            idx;
    int            g;
    int            r;
    logic          load;
    logic          exp_rdy;
    logic          accept;
    logic [NIN-1:0]  exp_kv;
    logic [NOUT-1:0] exp_kr;
    logic [NOUT*DW-1:0] sh;
    apply_reset();
    for (int i = 0; i < NIN; i++) mq[i].delete();
    m_ov = 1'b0; m_od = '0; m_dst = DST_BASE; m_ptr = 0; m_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge aclk);
      r = int'($urandom_range(0, 9));
      bus.lii_in_p0_tvalid  = ($urandom_range(0, 1) == 1);
      bus.lii_in_p0_dst     = (r < 4) ? 8'(IN_BASE) : (r < 8) ? 8'(IN_BASE + 1) : (r == 8) ? 8'(IN_BASE + 2) : 8'hFF;
      bus.lii_in_p0_src     = 8'($urandom);
      bus.lii_in_p0_tdata   = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NIN; i++) bus.k_in_tready[i] = ($urandom_range(0, 3) != 0);
      for (int s = 0; s < NOUT; s++) bus.k_out_tvalid[s] = ($urandom_range(0, 2) != 0);
      bus.k_out_tdata       = {rnd_dw(), rnd_dw()};
      bus.lii_out_p0_tready = ($urandom_range(0, 3) != 0);
      #1;
      idx     = (int'(bus.lii_in_p0_dst) - IN_BASE) & 255;
      exp_rdy = (idx < NIN) ? (mq[idx].size() < DEPTH) : 1'b1;
      for (int i = 0; i < NIN; i++) exp_kv[i] = (mq[i].size() > 0);
      load = !m_ov || bus.lii_out_p0_tready;
      g = -1;
      if (load) begin
        for (int k = 0; k < NOUT; k++) begin
          if (g < 0 && bus.k_out_tvalid[(m_ptr + k) % NOUT]) g = (m_ptr + k) % NOUT;
        end
      end
      exp_kr = (g >= 0) ? NOUT'(1 << g) : '0;
      total++; if (bus.lii_in_p0_tready !== exp_rdy) begin bad++; $display("FAIL rnd_in_rdy cyc=%0d got=%b exp=%b", cyc, bus.lii_in_p0_tready, exp_rdy); end
      total++; if (bus.k_in_tvalid !== exp_kv) begin bad++; $display("FAIL rnd_k_in_vld cyc=%0d got=%b exp=%b", cyc, bus.k_in_tvalid, exp_kv); end
      for (int i = 0; i < NIN; i++) begin
        if (mq[i].size() > 0) begin
          total++; if (bus.k_in_tdata[i*DW +: DW] !== mq[i][0]) begin bad++; $display("FAIL rnd_head%0d cyc=%0d got=%h exp=%h", i, cyc, bus.k_in_tdata[i*DW +: DW], mq[i][0]); end
        end
      end
      total++; if (bus.k_out_tready !== exp_kr) begin bad++; $display("FAIL rnd_k_out_rdy cyc=%0d got=%b exp=%b", cyc, bus.k_out_tready, exp_kr); end
      total++; if (bus.lii_out_p0_tvalid !== m_ov) begin bad++; $display("FAIL rnd_out_vld cyc=%0d got=%b exp=%b", cyc, bus.lii_out_p0_tvalid, m_ov); end
      if (m_ov) begin
        total++; if (bus.lii_out_p0_tdata !== m_od) begin bad++; $display("FAIL rnd_out_dat cyc=%0d got=%h exp=%h", cyc, bus.lii_out_p0_tdata, m_od); end
        total++; if (bus.lii_out_p0_dst !== 8'(m_dst)) begin bad++; $display("FAIL rnd_out_dst cyc=%0d got=%0d exp=%0d", cyc, bus.lii_out_p0_dst, m_dst); end
      end
      total++; if (bus.ce !== !(m_ov && !bus.lii_out_p0_tready)) begin bad++; $display("FAIL rnd_ce cyc=%0d got=%b", cyc, bus.ce); end
      total++; if (bus.drop_cnt !== 16'(m_drop)) begin bad++; $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", cyc, bus.drop_cnt, m_drop); end
      // advance the model by one clock
      accept = bus.lii_in_p0_tvalid && (idx < NIN) && exp_rdy;
      for (int i = 0; i < NIN; i++) begin
        if (bus.k_in_tready[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      end
      if (accept) mq[idx].push_back(bus.lii_in_p0_tdata[DW-1:0]);
      if (bus.lii_in_p0_tvalid && idx >= NIN && m_drop < 65535) m_drop++;
      if (load) begin
        if (g >= 0) begin
          sh    = bus.k_out_tdata >> (g * DW);
          m_ov  = 1'b1;
          m_od  = PW'(sh[DW-1:0]);
          m_dst = (DST_BASE + g) & 255;
          m_ptr = (g + 1) % NOUT;
        end else begin
          m_ov = 1'b0;
        end
      end
    end
    @(negedge aclk);
    idle_inputs();
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    bus.lii_in_p0_tvalid = 1'b1;
    bus.lii_in_p0_dst    = 8'd7;
    #1;
    total++; if (bus.lii_in_p0_tready !== 1'b1) begin bad++; $display("FAIL sat_rdy got=%b exp=1", bus.lii_in_p0_tready); end
    repeat (65534) @(posedge aclk);
    @(negedge aclk);
    #1;
    total++; if (bus.drop_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_below got=%h exp=fffe", bus.drop_cnt); end
    repeat (6) @(posedge aclk);
    @(negedge aclk);
    #1;
    total++; if (bus.drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", bus.drop_cnt); end
    total++; if (bus.k_in_tvalid !== 2'b00) begin bad++; $display("FAIL sat_fifo got=%b exp=00", bus.k_in_tvalid); end
    bus.lii_in_p0_tvalid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    arst  = 1'b1;
    idle_inputs();
    test_reset();
    test_demux();
    test_full_fifo();
    test_bad_dst();
    test_rr();
    test_backpressure();
    test_random();
    test_drop_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
